// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between a read-only
// fetch port and a read/write data port, one transaction at a time.
module mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int MEM_LATENCY    = 2,
   parameter int MEM_SIZE_BYTES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   output logic              if_rsp_err,
   input  logic              dc_req_valid,
   input  logic              dc_req_rw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [DATA_W-1:0] dc_req_wdata,
   output logic              dc_req_ready,
   output logic              dc_rsp_valid,
   output logic [DATA_W-1:0] dc_rsp_data,
   output logic              dc_rsp_err,
   output logic              mem_op_en,
   output logic              mem_rd_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);
   localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_SIZE_BYTES);
   localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DC = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic              last_grant_r;
   logic              owner_r;
   logic              rw_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] rsp_data_r;
   logic              rsp_err_r;
   logic              grant_if_s;
   logic              grant_dc_s;
   logic              handshake_s;
   logic [ADDR_W-1:0] req_addr_s;
   logic              in_range_s;

   // The port that did not win last time takes a tie.
   always_comb begin
      grant_if_s = 1'b0;
      grant_dc_s = 1'b0;
      if (state_r == IDLE) begin
         if (if_req_valid && (!dc_req_valid || (last_grant_r == OWN_DC))) begin
            grant_if_s = 1'b1;
         end else if (dc_req_valid) begin
            grant_dc_s = 1'b1;
         end else begin
            grant_if_s = 1'b0;
         end
      end else begin
         grant_dc_s = 1'b0;
      end
      handshake_s = grant_if_s | grant_dc_s;
      req_addr_s  = grant_dc_s ? dc_req_addr : if_req_addr;
      in_range_s  = (req_addr_s < MEM_LIMIT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (handshake_s) begin
               state_s = in_range_s ? ACCESS : RESP;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_s = RESP;
            end else begin
               state_s = ACCESS;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Request capture and response register; out-of-range requests skip memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_r <= OWN_DC;
         owner_r      <= OWN_IF;
         rw_r         <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         wdata_r      <= {DATA_W{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         rsp_data_r   <= {DATA_W{1'b0}};
         rsp_err_r    <= 1'b0;
      end else if (handshake_s) begin
         last_grant_r <= grant_dc_s;
         owner_r      <= grant_dc_s;
         rw_r         <= grant_dc_s & dc_req_rw;
         addr_r       <= req_addr_s & ALIGN_MASK;
         wdata_r      <= grant_dc_s ? dc_req_wdata : {DATA_W{1'b0}};
         cnt_r        <= CNT_LOAD;
         rsp_data_r   <= {DATA_W{1'b0}};
         rsp_err_r    <= ~in_range_s;
      end else if (state_r == ACCESS) begin
         cnt_r <= cnt_r - CNT_W'(1);
         if (cnt_r == {CNT_W{1'b0}}) begin
            rsp_data_r <= rw_r ? {DATA_W{1'b0}} : mem_rd_data;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   always_comb begin
      if_req_ready = grant_if_s;
      dc_req_ready = grant_dc_s;
      if_rsp_valid = 1'b0;
      if_rsp_data  = {DATA_W{1'b0}};
      if_rsp_err   = 1'b0;
      dc_rsp_valid = 1'b0;
      dc_rsp_data  = {DATA_W{1'b0}};
      dc_rsp_err   = 1'b0;
      mem_op_en    = 1'b0;
      mem_rd_wr    = 1'b0;
      mem_addr     = {ADDR_W{1'b0}};
      mem_wr_data  = {DATA_W{1'b0}};
      case (state_r)
         ACCESS: begin
            mem_op_en   = 1'b1;
            mem_rd_wr   = rw_r;
            mem_addr    = addr_r;
            mem_wr_data = wdata_r;
         end
         RESP: begin
            if (owner_r == OWN_DC) begin
               dc_rsp_valid = 1'b1;
               dc_rsp_data  = rsp_data_r;
               dc_rsp_err   = rsp_err_r;
            end else begin
               if_rsp_valid = 1'b1;
               if_rsp_data  = rsp_data_r;
               if_rsp_err   = rsp_err_r;
            end
         end
         default: begin
            mem_op_en = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port byte-addressed memory between two requesters: instruction fetch (IF, read-only) and data (DC, read/write).
- Handles one transaction at a time. Issues it to the memory with a fixed multi-cycle access window, then returns a single-cycle response pulse to the requester that owns it.
- Sits between the core's fetch/load-store units and the memory model. Grants round-robin so neither port starves.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- MEM_LATENCY, 2, number of cycles mem_op_en is held per access; must be >= 1.
- MEM_SIZE_BYTES, 64, memory size; addresses >= this are out of range.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  one-cycle fetch response pulse.
- if_rsp_data  out  DATA_W  fetch read data.
- if_rsp_err  out  1  fetch address out of range.
- dc_req_valid  in  1  data request.
- dc_req_rw  in  1  1 = write, 0 = read.
- dc_req_addr  in  ADDR_W  data byte address.
- dc_req_wdata  in  DATA_W  write data.
- dc_req_ready  out  1  data request accepted this cycle.
- dc_rsp_valid  out  1  one-cycle data response pulse; also sent for writes.
- dc_rsp_data  out  DATA_W  read data; 0 for writes.
- dc_rsp_err  out  1  data address out of range.
- mem_op_en  out  1  memory operation enable.
- mem_rd_wr  out  1  1 = write, 0 = read (memory's encoding).
- mem_addr  out  ADDR_W  memory byte address, word-aligned.
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory read data.

Behaviour:
- **Reset:** all outputs 0, state IDLE, last_grant = DC (so IF wins the first tie).
  - Assertion mid-transaction aborts it immediately: mem_op_en drops asynchronously, and no response is ever issued for the aborted request.
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - Ready is combinational: *_req_ready = 1 only for the granted port, and only in IDLE with its valid high.
  - Grant rules:
    - Only one port valid: that port wins.
    - Both valid: the port that was not last_grant wins.
  - On handshake (valid & ready):
    - Latch owner, rw (forced 0 for IF), addr with the low log2(DATA_W/8) bits cleared, and wdata.
    - Update last_grant.
    - In range (addr < MEM_SIZE_BYTES): go to ACCESS and load counter = MEM_LATENCY-1.
    - Out of range: go directly to RESP with err = 1 and no memory activity.
- **ACCESS:**
  - mem_op_en = 1; mem_rd_wr, mem_addr, mem_wr_data are driven from the latched values and held stable.
  - Counter decrements each cycle. On counter == 0, capture mem_rd_data (reads) or 0 (writes) into the response register, then go to RESP.
  - Outside ACCESS: mem_op_en = 0 and the other mem_* outputs are 0.
- **RESP:**
  - Owner's *_rsp_valid = 1 for exactly one cycle with data and err; the other port's rsp_valid = 0.
  - Next state is IDLE.
  - rsp_data/rsp_err are valid only while rsp_valid; they are 0 otherwise.
- **Timing:**
  - Handshake at cycle T (in range): mem_op_en high T+1 .. T+MEM_LATENCY; rsp_valid at T+MEM_LATENCY+1.
  - Earliest next handshake is T+MEM_LATENCY+2.
  - Out-of-range handshake at T: rsp_valid at T+1.
- **Request stability:** requesters hold valid/addr/wdata until ready. The arbiter ignores request inputs outside IDLE and does not require deassertion after a handshake; a still-high valid is a new request.
- **Write response:** rsp_data = 0, err = 0 when in range.
- **Boundaries:**
  - Both ports valid continuously: grants strictly alternate IF, DC, IF, DC.
  - Address = MEM_SIZE_BYTES-1: aligned down to a valid word, so it is in range.
  - Address = MEM_SIZE_BYTES: err.

Test Plan:
- **Reset then single IF read:** mem preloaded word @0x8 = 0xDEADBEEF; IF req addr 0x8 at T → if_req_ready at T; mem_op_en=1, mem_rd_wr=0, mem_addr=0x8 at T+1,T+2; if_rsp_valid=1, data=0xDEADBEEF, err=0 at T+3.
- **DC write then DC read:** write 0x12345678 @0x10 → dc_rsp_valid with data 0, mem_rd_wr=1 for 2 cycles; subsequent read @0x13 → mem_addr=0x10, dc_rsp_data=0x12345678.
- **Contention:** both valid every cycle for 4 transactions after reset → grant order IF, DC, IF, DC; each response goes to the correct port only; handshakes spaced 4 cycles apart.
- **Out of range:** DC read @0x40 at T → dc_rsp_valid=1, err=1 at T+1; mem_op_en never asserted.
- **Reset mid-ACCESS:** assert reset during the first ACCESS cycle of an IF read → mem_op_en drops before the next clock edge, no if_rsp_valid ever appears; after release, an IF request accepted normally and IF wins a tie.
